// File: rtl/hqm_aw_fifo_drain_skid_if.sv
// Bus bundle between the AW FIFO drain skid stage, its upstream FIFO and the downstream consumer.
// slave = the drain stage itself; master = whatever drives/observes it (FIFO side + consumer side).
interface hqm_aw_fifo_drain_skid_if #(
    parameter int DWIDTH   = 16,
    parameter int CNTWIDTH = 32
);
    logic                drain_en;
    logic                fifo_empty;
    logic [DWIDTH-1:0]   fifo_pop_data;
    logic                fifo_pop_par;
    logic                fifo_pop;
    logic                out_valid;
    logic                out_ready;
    logic [DWIDTH-1:0]   out_data;
    logic [1:0]          occupancy;
    logic [CNTWIDTH-1:0] drain_cnt;
    logic                par_err;

    modport slave (
        input  drain_en, fifo_empty, fifo_pop_data, fifo_pop_par, out_ready,
        output fifo_pop, out_valid, out_data, occupancy, drain_cnt, par_err
    );

    modport master (
        output drain_en, fifo_empty, fifo_pop_data, fifo_pop_par, out_ready,
        input  fifo_pop, out_valid, out_data, occupancy, drain_cnt, par_err
    );
endinterface

// File: rtl/hqm_aw_fifo_drain_skid.sv
// Drain stage after the AW FIFO: pops into a 2-entry skid buffer and presents a registered valid/ready output.
// Optional per-entry odd-parity check enabled by defining HQM_AW_FIFO_DRAIN_PAR_EN.
module hqm_aw_fifo_drain_skid #(
    parameter int DWIDTH   = 16,
    parameter int CNTWIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    hqm_aw_fifo_drain_skid_if.slave  bus
);

`ifdef HQM_AW_FIFO_DRAIN_PAR_EN
    localparam int EWIDTH = DWIDTH + 1;
`else
    localparam int EWIDTH = DWIDTH;
`endif

    logic [EWIDTH-1:0]   mem_q [2];
    logic [EWIDTH-1:0]   mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [CNTWIDTH-1:0] drain_cnt_q, drain_cnt_d;
    logic                par_err_q, par_err_d;

    logic                pop;
    logic                deliver;
    logic [EWIDTH-1:0]   entry_in;
    logic [EWIDTH-1:0]   head;

    // Handshake: an entry transfers on any clock where out_valid & out_ready; out_valid never
    // depends on out_ready, and the pop decision uses only inputs and registered occupancy.
    always_comb begin
        pop     = ~rst & ~bus.fifo_empty & bus.drain_en & (cnt_q < 2'd2);
        deliver = (cnt_q != 2'd0) & bus.out_ready;
        head    = mem_q[rd_ptr_q];
`ifdef HQM_AW_FIFO_DRAIN_PAR_EN
        entry_in = {bus.fifo_pop_par, bus.fifo_pop_data};
`else
        entry_in = bus.fifo_pop_data;
`endif

        mem_d[0]    = mem_q[0];
        mem_d[1]    = mem_q[1];
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drain_cnt_d = drain_cnt_q;
        par_err_d   = 1'b0;

        if (pop) begin
            mem_d[wr_ptr_q] = entry_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deliver) begin
            rd_ptr_d    = ~rd_ptr_q;
            drain_cnt_d = drain_cnt_q + 1'b1;
`ifdef HQM_AW_FIFO_DRAIN_PAR_EN
            // Stored data plus stored parity must have an odd number of ones.
            par_err_d   = ~(^head);
`endif
        end
        cnt_d = cnt_q + {1'b0, pop} - {1'b0, deliver};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            drain_cnt_q <= '0;
            par_err_q   <= 1'b0;
        end else begin
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            drain_cnt_q <= drain_cnt_d;
            par_err_q   <= par_err_d;
        end
    end

    assign bus.fifo_pop  = pop;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = head[DWIDTH-1:0];
    assign bus.occupancy = cnt_q;
    assign bus.drain_cnt = drain_cnt_q;
    assign bus.par_err   = par_err_q;

    occupancy_never_3 : assert property (@(posedge clk) disable iff (rst) cnt_q != 2'd3);

endmodule
